// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, ALU with ALU control, branch-target adder, EX/MEM register.
// Optional EX/MEM-to-EX operand forwarding is built when EX_FORWARD_EN is defined.
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        stall,
  input  logic [63:0] pc,
  input  logic [63:0] read_data_1,
  input  logic [63:0] read_data_2,
  input  logic [63:0] extended,
  input  logic [3:0]  Func,
  input  logic [1:0]  ALU_Op,
  input  logic        ALU_Src,
  input  logic        Mem_Write,
  input  logic        Mem_Read,
  input  logic        Mem_to_Reg,
  input  logic        Branch,
  input  logic        Reg_Write,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  output logic        out_valid,
  output logic [63:0] alu_result,
  output logic [63:0] write_data,
  output logic        zero,
  output logic [63:0] pc_branch,
  output logic        select,
  output logic        Mem_Write_out,
  output logic        Mem_Read_out,
  output logic        Mem_to_Reg_out,
  output logic        Reg_Write_out,
  output logic [4:0]  rd_out
);

  typedef struct packed {
    logic        v;
    logic [63:0] pc;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] ext;
    logic [3:0]  func;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic        branch;
    logic        reg_write;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_t;

  typedef struct packed {
    logic        v;
    logic [63:0] alu;
    logic [63:0] wdata;
    logic [63:0] target;
    logic        zero;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic        branch;
    logic        reg_write;
    logic [4:0]  rd;
  } exmem_t;

  idex_t  idex_d, idex_q;
  exmem_t exmem_d, exmem_q;

  logic [63:0] op_a, op_b, store_data, alu_res, target;

`ifdef EX_FORWARD_EN
  // Only a non-load ALU result sitting in EX/MEM can be forwarded; loads still need a gap.
  logic fwd_ok;
  assign fwd_ok     = exmem_q.v & exmem_q.reg_write & ~exmem_q.mem_to_reg & (exmem_q.rd != 5'd0);
  assign op_a       = (fwd_ok && exmem_q.rd == idex_q.rs1) ? exmem_q.alu : idex_q.rd1;
  assign store_data = (fwd_ok && exmem_q.rd == idex_q.rs2) ? exmem_q.alu : idex_q.rd2;
`else
  logic unused_rs;
  assign unused_rs  = ^{idex_q.rs1, idex_q.rs2};
  assign op_a       = idex_q.rd1;
  assign store_data = idex_q.rd2;
`endif

  assign op_b   = idex_q.alu_src ? idex_q.ext : store_data;
  assign target = idex_q.pc + (idex_q.ext << 1);

  always_comb begin
    alu_res = '0;
    case (idex_q.alu_op)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b10: begin
        case (idex_q.func)
          4'b0000: alu_res = op_a + op_b;
          4'b1000: alu_res = op_a - op_b;
          4'b0111: alu_res = op_a & op_b;
          4'b0110: alu_res = op_a | op_b;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // A taken branch in EX/MEM kills both younger slots: the one moving into EX/MEM and the one entering ID/EX.
  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    if (!stall) begin
      idex_d.v          = in_valid & ~select;
      idex_d.pc         = pc;
      idex_d.rd1        = read_data_1;
      idex_d.rd2        = read_data_2;
      idex_d.ext        = extended;
      idex_d.func       = Func;
      idex_d.alu_op     = ALU_Op;
      idex_d.alu_src    = ALU_Src;
      idex_d.mem_write  = Mem_Write;
      idex_d.mem_read   = Mem_Read;
      idex_d.mem_to_reg = Mem_to_Reg;
      idex_d.branch     = Branch;
      idex_d.reg_write  = Reg_Write;
      idex_d.rs1        = rs1;
      idex_d.rs2        = rs2;
      idex_d.rd         = rd;

      exmem_d.v          = idex_q.v & ~select;
      exmem_d.alu        = alu_res;
      exmem_d.wdata      = store_data;
      exmem_d.target     = target;
      exmem_d.zero       = (alu_res == 64'd0);
      exmem_d.mem_write  = idex_q.mem_write;
      exmem_d.mem_read   = idex_q.mem_read;
      exmem_d.mem_to_reg = idex_q.mem_to_reg;
      exmem_d.branch     = idex_q.branch;
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.rd         = idex_q.rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end

  assign out_valid      = exmem_q.v;
  assign alu_result     = exmem_q.alu;
  assign write_data     = exmem_q.wdata;
  assign zero           = exmem_q.zero;
  assign pc_branch      = exmem_q.target;
  assign rd_out         = exmem_q.rd;
  assign select         = exmem_q.v & exmem_q.branch & exmem_q.zero;
  assign Mem_Write_out  = exmem_q.v & exmem_q.mem_write;
  assign Mem_Read_out   = exmem_q.v & exmem_q.mem_read;
  assign Mem_to_Reg_out = exmem_q.v & exmem_q.mem_to_reg;
  assign Reg_Write_out  = exmem_q.v & exmem_q.reg_write;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, load/store, branch flush, stall, forwarding, reset.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid, stall;
  logic [63:0] pc, read_data_1, read_data_2, extended;
  logic [3:0]  Func;
  logic [1:0]  ALU_Op;
  logic        ALU_Src, Mem_Write, Mem_Read, Mem_to_Reg, Branch, Reg_Write;
  logic [4:0]  rs1, rs2, rd;
  logic        out_valid, zero, select;
  logic [63:0] alu_result, write_data, pc_branch;
  logic        Mem_Write_out, Mem_Read_out, Mem_to_Reg_out, Reg_Write_out;
  logic [4:0]  rd_out;

  int tests = 0;
  int fails = 0;

  execute_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .pc(pc),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .extended(extended),
    .Func(Func), .ALU_Op(ALU_Op), .ALU_Src(ALU_Src), .Mem_Write(Mem_Write),
    .Mem_Read(Mem_Read), .Mem_to_Reg(Mem_to_Reg), .Branch(Branch), .Reg_Write(Reg_Write),
    .rs1(rs1), .rs2(rs2), .rd(rd), .out_valid(out_valid), .alu_result(alu_result),
    .write_data(write_data), .zero(zero), .pc_branch(pc_branch), .select(select),
    .Mem_Write_out(Mem_Write_out), .Mem_Read_out(Mem_Read_out),
    .Mem_to_Reg_out(Mem_to_Reg_out), .Reg_Write_out(Reg_Write_out), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    in_valid = 0; stall = 0; pc = 0; read_data_1 = 0; read_data_2 = 0; extended = 0;
    Func = 0; ALU_Op = 0; ALU_Src = 0; Mem_Write = 0; Mem_Read = 0; Mem_to_Reg = 0;
    Branch = 0; Reg_Write = 0; rs1 = 0; rs2 = 0; rd = 0;
  endtask

  task automatic rtype(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b, input logic [4:0] d);
    idle();
    in_valid = 1; ALU_Op = 2'b10; Func = f; read_data_1 = a; read_data_2 = b; rd = d; Reg_Write = 1;
  endtask

  initial begin
    idle();
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_alu_result", alu_result, 0);
    chk("reset_pc_branch", pc_branch, 0);
    chk("reset_select", select, 0);
    tick();
    tick();
    reset = 1;

    // add: 5 + 7 -> 12, two edges later
    rtype(4'b0000, 64'd5, 64'd7, 5'd5);
    tick();
    idle();
    chk("add_not_yet_valid", out_valid, 0);
    tick();
    chk("add_result", alu_result, 64'd12);
    chk("add_zero", zero, 0);
    chk("add_rd_out", rd_out, 5);
    chk("add_out_valid", out_valid, 1);
    chk("add_reg_write", Reg_Write_out, 1);

    // load address: 0x100 + (-8)
    idle();
    in_valid = 1; ALU_Src = 1; read_data_1 = 64'h100; extended = 64'hFFFF_FFFF_FFFF_FFF8;
    Mem_Read = 1; Mem_to_Reg = 1; Reg_Write = 1; rd = 5'd3;
    tick();
    // store follows back to back: 0x40 + 8, data 0xABCD
    idle();
    in_valid = 1; ALU_Src = 1; read_data_1 = 64'h40; extended = 64'd8; read_data_2 = 64'hABCD;
    Mem_Write = 1;
    tick();
    chk("load_addr", alu_result, 64'hF8);
    chk("load_mem_read", Mem_Read_out, 1);
    chk("load_mem_to_reg", Mem_to_Reg_out, 1);
    chk("load_mem_write", Mem_Write_out, 0);
    // R-type sequence: sub, and, or, unsupported Func, ALU_Op 11
    rtype(4'b1000, 64'd3, 64'd5, 5'd1);
    tick();
    chk("store_addr", alu_result, 64'h48);
    chk("store_data", write_data, 64'hABCD);
    chk("store_mem_write", Mem_Write_out, 1);
    chk("store_reg_write", Reg_Write_out, 0);
    rtype(4'b0111, 64'hF0F0, 64'hFF00, 5'd2);
    tick();
    chk("sub_result", alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
    rtype(4'b0110, 64'hF0F0, 64'hFF00, 5'd3);
    tick();
    chk("and_result", alu_result, 64'hF000);
    rtype(4'b0001, 64'd9, 64'd4, 5'd4);
    tick();
    chk("or_result", alu_result, 64'hFFF0);
    idle();
    in_valid = 1; ALU_Op = 2'b11; read_data_1 = 64'd9; read_data_2 = 64'd4; rd = 5'd4;
    tick();
    chk("badfunc_result", alu_result, 0);
    chk("badfunc_zero", zero, 1);
    idle();
    tick();
    chk("aluop11_result", alu_result, 0);
    chk("aluop11_valid", out_valid, 1);
    tick();

    // taken beq with two younger instructions behind it
    idle();
    in_valid = 1; ALU_Op = 2'b01; Branch = 1; read_data_1 = 64'd42; read_data_2 = 64'd42;
    pc = 64'd1; extended = 64'd8;
    tick();
    rtype(4'b0000, 64'd1, 64'd1, 5'd7);
    tick();
    chk("beq_select", select, 1);
    chk("beq_zero", zero, 1);
    chk("beq_target", pc_branch, 64'd17);
    chk("beq_reg_write", Reg_Write_out, 0);
    rtype(4'b0000, 64'd2, 64'd3, 5'd8);
    tick();
    idle();
    chk("beq_select_one_cycle", select, 0);
    chk("flushed_next_valid", out_valid, 0);
    chk("flushed_next_reg_write", Reg_Write_out, 0);
    tick();
    chk("flushed_second_valid", out_valid, 0);
    chk("flushed_second_alu", alu_result, 64'd5);

    // stall: add captured, then held three cycles
    rtype(4'b0000, 64'd10, 64'd20, 5'd9);
    tick();
    rtype(4'b0000, 64'd99, 64'd99, 5'd10);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid_held", out_valid, 0);
      chk("stall_alu_held", alu_result, 0);
    end
    idle();
    tick();
    chk("stall_release_result", alu_result, 64'd30);
    chk("stall_release_valid", out_valid, 1);
    chk("stall_release_rd", rd_out, 9);
    tick();
    chk("stall_dropped_input", out_valid, 0);

    // back-to-back dependency: x5 = 1 + 2, then x6 = x5 + x5 with stale operands
    rtype(4'b0000, 64'd1, 64'd2, 5'd5);
    tick();
    rtype(4'b0000, 64'd0, 64'd0, 5'd6);
    rs1 = 5'd5; rs2 = 5'd5;
    tick();
    idle();
    chk("fwd_producer", alu_result, 64'd3);
    tick();
`ifdef EX_FORWARD_EN
    chk("fwd_consumer", alu_result, 64'd6);
`else
    chk("fwd_consumer", alu_result, 64'd0);
`endif
    tick();

    // reset with two instructions in flight
    rtype(4'b0000, 64'd4, 64'd4, 5'd11);
    pc = 64'h1000; extended = 64'd4;
    tick();
    rtype(4'b0000, 64'd6, 64'd6, 5'd12);
    tick();
    idle();
    chk("pre_reset_valid", out_valid, 1);
    #2;
    reset = 0;
    #1;
    chk("midreset_valid", out_valid, 0);
    chk("midreset_alu", alu_result, 0);
    chk("midreset_pc_branch", pc_branch, 0);
    chk("midreset_reg_write", Reg_Write_out, 0);
    chk("midreset_rd_out", rd_out, 0);
    tick();
    reset = 1;
    tick();
    chk("post_reset_valid_1", out_valid, 0);
    tick();
    chk("post_reset_valid_2", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
